fp_adder_arbiter: RTL
=====================

Name: fp_adder_arbiter

Overview:
Shares one combinational IEEE_754_Adder among NUM_REQ requesters, e.g. the row/column accumulators of the matrix-multiply array. Arbitration is round-robin. Operands pass through a registered operand stage that drives the shared adder. The adder output is captured in a response register with valid/ready backpressure, so the adder never sees a combinational path from requester inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, requester-index width, must equal clog2(NUM_REQ)
FP_W, 32, operand/result width (IEEE-754 single)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand-pair valid
req_ready  out  NUM_REQ  one-hot transfer acknowledge
req_num1  in  NUM_REQ*FP_W  packed first operands, requester i at [i*FP_W +: FP_W]
req_num2  in  NUM_REQ*FP_W  packed second operands
add_num1  out  FP_W  to shared adder num1 (registered)
add_num2  out  FP_W  to shared adder num2 (registered)
add_result  in  FP_W  from shared adder result (combinational)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_result  out  FP_W  sum
rsp_id  out  ID_W  index of the requester that issued it
busy  out  1  op_valid | rsp_valid

Behaviour:
- Reset (rst_n low at a rising edge): req_ready=0, add_num1/add_num2=0, rsp_valid=0, rsp_result=0, rsp_id=0, busy=0, rr_ptr=0. Any in-flight operations are discarded, with no response.
- Pipeline stages:
  - S1 operand register: op_valid, op_id, add_num1, add_num2.
  - S2 response register: rsp_valid, rsp_id, rsp_result.
- Advance conditions:
  - rsp_take = ~rsp_valid | rsp_ready.
  - op_adv = op_valid & rsp_take.
  - s1_free = ~op_valid | op_adv.
- Grant:
  - Search order is rr_ptr, rr_ptr+1, … wrapping modulo NUM_REQ.
  - The first requester with req_valid set wins, only when s1_free=1.
  - req_ready[w]=1 for the winner only; all other bits are 0. req_ready is combinational from req_valid, rr_ptr and stall state.
- Transfer: on req_valid[i] & req_ready[i], the next edge loads op_valid=1, op_id=i, add_num1/add_num2 from requester i, and sets rr_ptr=(i+1) mod NUM_REQ.
- rr_ptr is unchanged when no grant occurs.
- Requester rules: once req_valid is raised, it and the operands stay stable until req_ready. Requesters never drop valid early. The arbiter does not check this.
- On op_adv, the next edge loads rsp_valid=1, rsp_result=add_result, rsp_id=op_id.
- If op_valid=0 and rsp_take=1, rsp_valid clears.
- Latency: request accepted at edge N → add_num* valid after N → rsp_valid after edge N+1. That is 2 cycles from acceptance to response.
- Throughput: one result per cycle while rsp_ready=1. Simultaneous advance of S1→S2 and a new grant into S1 in the same cycle is required.
- Backpressure:
  - With rsp_valid=1 and rsp_ready=0, S2 holds.
  - If S1 is also full, S1 holds, add_num* stay stable, and req_ready=0.
  - If S1 is empty, one more grant is accepted; the pipeline then holds at most 2 outstanding operations.
- rsp_ready is a don't-care while rsp_valid=0.
- Single requester active: it is granted every cycle the pipeline accepts, since fairness only applies among active requesters.
- The block performs no arithmetic and passes NaN/Inf/denormal encodings untouched. Result semantics belong to the adder.
- Reset asserted mid-operation takes priority over every handshake in that cycle.

Decomposition:
- Shared package fp_pkg:
  - FP_W=32.
  - Constants FP_ZERO=32'h00000000, FP_NEG_ZERO=32'h80000000, FP_POS_INF=32'h7F800000, FP_ONE=32'h3F800000.
  - Typedef fp_t (logic [FP_W-1:0]).
  - clog2 helper function.
- Sub-module rr_arbiter, purely combinational:
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant, grant index, any_grant.
  - Implementation: rotate by ptr, priority-encode, rotate back.
  - Reused by later shared-multiplier arbitration.

Test Plan:
1. Reset check: hold rst_n=0 for 3 cycles with all req_valid=1 → req_ready=0, rsp_valid=0, add_num*=0, busy=0. Release → first grant goes to requester 0.
2. Single requester: req 2 with num1=0x40C00000, num2=0x00000000 → rsp_valid asserts 2 cycles after acceptance with rsp_result=0x40C00000, rsp_id=2.
3. Round-robin: all 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,…, one response per cycle. Req 1 sends 0x3F800000+0x3F800000 and its response is 0x40000000 with rsp_id=1.
4. Backpressure: rsp_ready=0 with streaming requests → exactly 2 acceptances, then req_ready=0 and add_num*/rsp_* stable. Raise rsp_ready → responses drain in acceptance order with no loss or duplication.
5. Pointer wrap / sparse requests: only req 3 valid, then only req 0 and req 3 valid → grant order 3, then 0, then 3.
6. Reset mid-flight: assert rst_n=0 with S1 and S2 full → next cycle rsp_valid=0, busy=0, rr_ptr=0, and no stale response appears after release.

Source files
------------

// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared floating-point definitions for the arithmetic blocks that sit around
// the matrix-multiply array.
//   FP_W        : operand/result width (IEEE-754 single precision)
//   fp_t        : one IEEE-754 single-precision word
//   FP_*        : commonly used encodings
//   clog2()     : ceiling log2, used for sizing index fields at elaboration
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int FP_W = 32;

    typedef logic [FP_W-1:0] fp_t;

    localparam fp_t FP_ZERO     = 32'h00000000;
    localparam fp_t FP_NEG_ZERO = 32'h80000000;
    localparam fp_t FP_POS_INF  = 32'h7F800000;
    localparam fp_t FP_ONE      = 32'h3F800000;

    // Smallest r such that 2**r >= value; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_adder_arbiter_if.sv
// ---------------------------------------------------------------------------
// fp_adder_arbiter_if
// Bundles the three buses around the shared-adder arbiter:
//   req_*  : NUM_REQ requesters, valid/ready, operands packed at [i*FP_W +: FP_W]
//   add_*  : operands to / sum from the shared combinational adder
//   rsp_*  : registered response with valid/ready backpressure and issuer id
//   busy   : an operation is held somewhere in the arbiter pipeline
// Modports:
//   slave  : the arbiter side
//   master : the environment side (requesters, adder and response consumer)
// ---------------------------------------------------------------------------
interface fp_adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int FP_W    = fp_pkg::FP_W
);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*FP_W-1:0] req_num1;
    logic [NUM_REQ*FP_W-1:0] req_num2;

    logic [FP_W-1:0]         add_num1;
    logic [FP_W-1:0]         add_num2;
    logic [FP_W-1:0]         add_result;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [FP_W-1:0]         rsp_result;
    logic [ID_W-1:0]         rsp_id;

    logic                    busy;

    modport slave (
        input  req_valid, req_num1, req_num2, add_result, rsp_ready,
        output req_ready, add_num1, add_num2, rsp_valid, rsp_result, rsp_id, busy
    );

    modport master (
        output req_valid, req_num1, req_num2, add_result, rsp_ready,
        input  req_ready, add_num1, add_num2, rsp_valid, rsp_result, rsp_id, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The request vector is rotated so
// that requester 'ptr' sits at bit 0, the lowest set bit is found, and the
// offset is rotated back into an absolute requester index.
//   req       : per-requester request bits
//   ptr       : requester with highest priority this cycle (must be < NUM_REQ)
//   enable    : when low, no grant is issued
//   grant     : one-hot grant (all zero when nothing is granted)
//   grant_idx : index of the granted requester (meaningless when !any_grant)
//   any_grant : a grant is being issued
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W:0]        ptr_ext;
    logic [ID_W-1:0]      offset;
    logic                 found;
    logic [ID_W:0]        idx_sum;

    // Doubling the vector turns the rotation into a plain part-select.
    assign req_dbl = {req, req};
    assign ptr_ext = {1'b0, ptr};
    assign req_rot = req_dbl[ptr_ext +: NUM_REQ];

    // Lowest set bit of the rotated vector is the first requester at or after ptr.
    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_rot[i]) begin
                offset = ID_W'(i);
                found  = 1'b1;
            end
        end
    end

    // Rotate back; the sum is reduced modulo NUM_REQ so non-power-of-two sizes work.
    always_comb begin
        idx_sum = ptr_ext + {1'b0, offset};
        if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
            idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
        end
    end

    assign grant_idx = idx_sum[ID_W-1:0];
    assign any_grant = enable & found;
    assign grant     = any_grant ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/fp_adder_arbiter.sv
// ---------------------------------------------------------------------------
// fp_adder_arbiter
// Shares one combinational IEEE-754 adder among NUM_REQ requesters with
// round-robin arbitration. Two register stages isolate the adder:
//   S1 operand register  : op_valid, op_id, add_num1, add_num2 (drives adder)
//   S2 response register : rsp_valid, rsp_id, rsp_result (captures adder sum)
// Both stages advance together, so one result per cycle is sustained while
// the consumer is ready; under backpressure at most two operations are held.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, discards in-flight operations
//   bus   : fp_adder_arbiter_if.slave (request, adder and response buses)
// ---------------------------------------------------------------------------
module fp_adder_arbiter
    import fp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int FP_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_adder_arbiter_if.slave  bus
);

    if ((NUM_REQ < 2) || (NUM_REQ > 16)) begin : g_num_req_check
        $error("fp_adder_arbiter: NUM_REQ must be within 2..16");
    end
    if (ID_W != clog2(NUM_REQ)) begin : g_id_w_check
        $error("fp_adder_arbiter: ID_W must equal clog2(NUM_REQ)");
    end

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    next_ptr;

    logic               op_valid;
    logic [ID_W-1:0]    op_id;
    logic [FP_W-1:0]    op_num1;
    logic [FP_W-1:0]    op_num2;

    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [FP_W-1:0]    rsp_result_q;

    logic               rsp_take;
    logic               op_adv;
    logic               s1_free;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any_grant;
    logic [FP_W-1:0]    sel_num1;
    logic [FP_W-1:0]    sel_num2;

    // S2 can accept when empty or being drained; S1 can accept when empty or
    // moving into S2 this cycle, which lets a grant overlap the S1->S2 move.
    assign rsp_take = ~rsp_valid_q | bus.rsp_ready;
    assign op_adv   = op_valid & rsp_take;
    assign s1_free  = ~op_valid | op_adv;

    // Gating with rst_n keeps req_ready low while reset is held, so no
    // requester believes a transfer happened on an edge that resets the block.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .enable    (s1_free & rst_n),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign bus.req_ready = grant;

    // Operand mux for the winner and the pointer that follows it.
    always_comb begin
        sel_num1 = bus.req_num1[grant_idx*FP_W +: FP_W];
        sel_num2 = bus.req_num2[grant_idx*FP_W +: FP_W];
        if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + 1'b1;
        end
    end

    // S1 operand stage and round-robin pointer. A grant reloads S1 even when
    // the previous operation is leaving in the same cycle; otherwise S1 only
    // empties when its contents move on. add_num* keep their last value when
    // S1 empties, so the adder input does not toggle needlessly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_id    <= '0;
            op_num1  <= '0;
            op_num2  <= '0;
            rr_ptr   <= '0;
        end else begin
            if (any_grant) begin
                op_valid <= 1'b1;
                op_id    <= grant_idx;
                op_num1  <= sel_num1;
                op_num2  <= sel_num2;
                rr_ptr   <= next_ptr;
            end else if (op_adv) begin
                op_valid <= 1'b0;
            end
        end
    end

    // S2 response stage: captures the adder sum when S1 advances, and empties
    // once the consumer has taken it with nothing behind it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            if (op_adv) begin
                rsp_valid_q  <= 1'b1;
                rsp_id_q     <= op_id;
                rsp_result_q <= bus.add_result;
            end else if (rsp_take) begin
                rsp_valid_q  <= 1'b0;
            end
        end
    end

    assign bus.add_num1   = op_num1;
    assign bus.add_num2   = op_num2;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.busy       = op_valid | rsp_valid_q;

endmodule
